instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch-side initiator for the 256 x 16-bit combinational instruction ROM.
- Owns the program counter and drives it to the ROM.
- Captures the returned instruction into a one-entry output register and hands it to decode over a valid/ready handshake.
- Handles redirects from execute and, optionally, pre-decodes unconditional JMP so the next fetch follows the jump target immediately.

Parameters:
ADDR_W, 8, PC/ROM address width
INSTR_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset
JMP_OPCODE, 4'b1111, opcode in instruction[INSTR_W-1:INSTR_W-4] identifying JMP; target = instruction[ADDR_W-1:0]
PREDECODE_JMP, 1, 1 = fetch follows JMP targets itself; 0 = sequential fetch only

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  permit new fetches
redirect_valid  input  1  execute-stage PC redirect, single-cycle pulse
redirect_pc  input  ADDR_W  redirect target
pc  output  ADDR_W  address to instruction ROM (registered)
instruction  input  INSTR_W  ROM data for pc, combinational same cycle
if_valid  output  1  decode-side output holds an instruction
if_ready  input  1  decode accepts this cycle
if_instr  output  INSTR_W  captured instruction
if_pc  output  ADDR_W  address if_instr was fetched from
if_jmp_taken  output  1  if_instr is a JMP already followed by fetch
fetch_count  output  16  accepted-transfer count, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync release) sets:
  - pc=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_jmp_taken=0; fetch_count=0; state=IDLE.
- States:
  - IDLE: no capture. Go to RUN when fetch_en=1. The first capture occurs in the cycle after RUN is entered.
  - RUN: go to DRAIN when fetch_en=0.
  - DRAIN: no capture. Go to IDLE when if_valid=0 or transfer occurs. Return to RUN if fetch_en=1 again.
- Transfer: if_valid && if_ready in the same cycle.
- slot_free: !if_valid || transfer.
- Capture (RUN && slot_free && !redirect_valid) on the clock edge performs all of:
  - if_instr<=instruction, if_pc<=pc, if_valid<=1.
  - is_jmp = PREDECODE_JMP && opcode==JMP_OPCODE.
  - if_jmp_taken<=is_jmp.
  - pc<=is_jmp ? instruction[ADDR_W-1:0] : pc+1.
- PC increment wraps modulo 2^ADDR_W (0xFF -> 0x00).
- Transfer without capture (DRAIN, or RUN with redirect): if_valid<=0.
- Holding: if_valid=1 && !if_ready keeps if_instr/if_pc/if_jmp_taken/if_valid stable and pc unchanged. Valid never drops without a transfer or redirect.
- Redirect has highest priority in every state:
  - pc<=redirect_pc; if_valid<=0 (flush); no capture that cycle.
  - A transfer in the same cycle still counts in fetch_count.
  - The first capture at the redirect target occurs the next cycle if state=RUN.
  - Redirect in IDLE/DRAIN only updates pc and flushes.
- Throughput: with if_ready held 1 and no redirect, one instruction per cycle. if_pc sequence has no bubbles, including across a pre-decoded JMP.
- fetch_count increments by 1 per transfer and holds at 16'hFFFF.
- pc changes only on clock edges, so the ROM address is glitch-free. instruction is sampled only during capture.
- Reset asserted mid-operation immediately forces all reset values, regardless of the handshake in progress.

Test Plan:
- Sequential stream:
  - Stimulus: ROM 0..3 = 16'h1123, 16'h2114, 16'h6104, 16'h7108; fetch_en=1, if_ready=1 after reset.
  - Required: if_pc 0,1,2,3 on consecutive cycles with the matching if_instr; fetch_count=4 after the fourth transfer.
- Pre-decoded JMP:
  - Stimulus: ROM[4]=16'hF000, PREDECODE_JMP=1.
  - Required: if_pc sequence 3,4,0,1 with no bubble; if_jmp_taken=1 only with if_pc=4.
  - Same run with PREDECODE_JMP=0: if_pc after 4 is 5 and if_jmp_taken stays 0.
- Backpressure:
  - Stimulus: hold if_ready=0 for 3 cycles while if_valid=1 at if_pc=2.
  - Required: if_instr=16'h6104, if_pc=2 stable and pc=3 unchanged throughout; release -> if_pc=3 next cycle.
- Redirect:
  - Stimulus: redirect_valid pulse with redirect_pc=8'h10 while if_valid=1, if_ready=1.
  - Required: that transfer counted; if_valid=0 next cycle; pc=8'h10; following cycle if_pc=8'h10.
  - Redirect with pc=8'hFF vs natural wrap: both yield fetch of 8'h00 after 8'hFF.
- Enable/drain:
  - Stimulus: drop fetch_en while if_valid=1, if_ready=0.
  - Required: DRAIN holds the instruction; after one transfer if_valid=0, state IDLE, pc frozen; raise fetch_en -> resumes at frozen pc.
- Async reset:
  - Stimulus: assert rst_n=0 mid-stream between clock edges.
  - Required: pc=RESET_PC, if_valid=0, fetch_count=0 immediately without a clock edge; first fetch after release+fetch_en at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch-side initiator for a combinational instruction ROM: owns the PC, captures the
// returned word into a one-entry register and offers it to decode over valid/ready.
//
// state | meaning
// IDLE  | fetch disabled, PC frozen, nothing captured
// RUN   | capture one instruction per cycle whenever the output slot is free
// DRAIN | fetch disabled, waiting for the held instruction to be taken
module instruction_fetch #(
    parameter int                ADDR_W        = 8,
    parameter int                INSTR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0,
    parameter logic [3:0]        JMP_OPCODE    = 4'b1111,
    parameter bit                PREDECODE_JMP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instruction,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_jmp_taken,
    output logic [15:0]        fetch_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic               jmp_q, jmp_d;
    logic [15:0]        count_q, count_d;

    logic transfer;
    logic slot_free;
    logic capture;
    logic is_jmp;

    assign transfer  = valid_q && if_ready;
    assign slot_free = !valid_q || transfer;
    assign capture   = (state_q == RUN) && slot_free && !redirect_valid;
    assign is_jmp    = PREDECODE_JMP && (instruction[INSTR_W-1 -: 4] == JMP_OPCODE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en) state_d = RUN;
            RUN:     if (!fetch_en) state_d = DRAIN;
            DRAIN: begin
                if (fetch_en)                     state_d = RUN;
                else if (!valid_q || transfer)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Redirect wins over capture; a transfer in the same cycle is still counted below.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        jmp_d   = jmp_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else if (capture) begin
            instr_d = instruction;
            if_pc_d = pc_q;
            valid_d = 1'b1;
            jmp_d   = is_jmp;
            pc_d    = is_jmp ? instruction[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (transfer && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            if_pc_q <= '0;
            jmp_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
            jmp_q   <= jmp_d;
            count_q <= count_d;
        end
    end

    assign pc           = pc_q;
    assign if_valid     = valid_q;
    assign if_instr     = instr_q;
    assign if_pc        = if_pc_q;
    assign if_jmp_taken = jmp_q;
    assign fetch_count  = count_q;

endmodule
